// File: rtl/fpdiv_ctrl.sv
// Control FSM for a Goldschmidt floating-point divider datapath.
// Sequences the multiplier operand selects and register load enables.
module fpdiv_ctrl #(
  parameter int unsigned ITER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic [1:0] sel_mux3,
  output logic [1:0] sel_mux4,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_A0,
    S_B0,
    S_AI,
    S_BI,
    S_REM,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic       en_a_nxt, en_b_nxt, en_rem_nxt, busy_nxt, done_nxt;
  logic [1:0] sel_mux3_nxt, sel_mux4_nxt;

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      en_a     <= 1'b0;
      en_b     <= 1'b0;
      en_rem   <= 1'b0;
      sel_mux3 <= 2'd0;
      sel_mux4 <= 2'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      en_a     <= en_a_nxt;
      en_b     <= en_b_nxt;
      en_rem   <= en_rem_nxt;
      sel_mux3 <= sel_mux3_nxt;
      sel_mux4 <= sel_mux4_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  // Next state, then outputs decoded from the state being entered so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    en_a_nxt     = 1'b0;
    en_b_nxt     = 1'b0;
    en_rem_nxt   = 1'b0;
    sel_mux3_nxt = 2'd0;
    sel_mux4_nxt = 2'd0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      S_IDLE: if (start) state_nxt = S_A0;
      S_A0:   state_nxt = S_B0;
      S_B0: begin
        state_nxt = S_AI;
        cnt_nxt   = '0;
      end
      S_AI:   state_nxt = S_BI;
      S_BI: begin
        if (cnt != CNT_LAST) begin
          state_nxt = S_AI;
          cnt_nxt   = cnt + CNT_W'(1);
        end else begin
          state_nxt = S_REM;
        end
      end
      S_REM:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_A0: begin
        en_a_nxt = 1'b1;
        busy_nxt = 1'b1;
      end
      S_B0: begin
        sel_mux4_nxt = 2'd1;
        en_b_nxt     = 1'b1;
        busy_nxt     = 1'b1;
      end
      S_AI: begin
        sel_mux3_nxt = 2'd1;
        sel_mux4_nxt = 2'd2;
        en_a_nxt     = 1'b1;
        busy_nxt     = 1'b1;
      end
      S_BI: begin
        sel_mux3_nxt = 2'd1;
        sel_mux4_nxt = 2'd3;
        en_b_nxt     = 1'b1;
        busy_nxt     = 1'b1;
      end
      S_REM: begin
        sel_mux3_nxt = 2'd2;
        sel_mux4_nxt = 2'd2;
        en_rem_nxt   = 1'b1;
        busy_nxt     = 1'b1;
      end
      S_DONE:  done_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl: ITER=3 and ITER=1 instances share stimulus,
// a per-cycle behavioural schedule predicts each instance's output vector.
module tb_fpdiv_ctrl;

  // {sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done}
  typedef logic [8:0] vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;

  logic       en_a3, en_b3, en_rem3, busy3, done3;
  logic [1:0] sel3_3, sel4_3;
  logic       en_a1, en_b1, en_rem1, busy1, done1;
  logic [1:0] sel3_1, sel4_1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITER(3)) dut3 (
    .clk(clk), .reset(reset), .start(start),
    .en_a(en_a3), .en_b(en_b3), .en_rem(en_rem3),
    .sel_mux3(sel3_3), .sel_mux4(sel4_3), .busy(busy3), .done(done3)
  );

  fpdiv_ctrl #(.ITER(1)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .en_a(en_a1), .en_b(en_b1), .en_rem(en_rem1),
    .sel_mux3(sel3_1), .sel_mux4(sel4_1), .busy(busy1), .done(done1)
  );

  function automatic vec_t mkv(input logic [1:0] s3, input logic [1:0] s4,
                               input logic a, input logic b, input logic r,
                               input logic bz, input logic d);
    return {s3, s4, a, b, r, bz, d};
  endfunction

  localparam vec_t V_IDLE = 9'b0;

  int unsigned iters [2] = '{3, 1};
  vec_t        sched [2][$];
  vec_t        expq  [2][$];
  bit          idle_now [2] = '{1'b1, 1'b1};

  // Reference: a division is a fixed list of per-cycle output vectors that
  // is only started when the block was idle in the previous cycle.
  always @(posedge clk) begin
    vec_t v;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        sched[k].delete();
        v = V_IDLE;
      end else begin
        if (sched[k].size() == 0 && idle_now[k] && start) begin
          sched[k].push_back(mkv(2'd0, 2'd0, 1, 0, 0, 1, 0));
          sched[k].push_back(mkv(2'd0, 2'd1, 0, 1, 0, 1, 0));
          for (int i = 0; i < int'(iters[k]); i++) begin
            sched[k].push_back(mkv(2'd1, 2'd2, 1, 0, 0, 1, 0));
            sched[k].push_back(mkv(2'd1, 2'd3, 0, 1, 0, 1, 0));
          end
          sched[k].push_back(mkv(2'd2, 2'd2, 0, 0, 1, 1, 0));
          sched[k].push_back(mkv(2'd0, 2'd0, 0, 0, 0, 0, 1));
        end
        v = (sched[k].size() > 0) ? sched[k].pop_front() : V_IDLE;
      end
      idle_now[k] = (v == V_IDLE);
      expq[k].push_back(v);
    end
  end

  // Monitor: every cycle the DUT presents an output vector; compare mid-cycle.
  always @(negedge clk) begin
    vec_t act;
    vec_t exp_v;
    for (int k = 0; k < 2; k++) begin
      if (expq[k].size() > 0) begin
        exp_v = expq[k].pop_front();
        act = (k == 0) ? {sel3_3, sel4_3, en_a3, en_b3, en_rem3, busy3, done3}
                       : {sel3_1, sel4_1, en_a1, en_b1, en_rem1, busy1, done1};
        n_cmp++;
        if (act !== exp_v) begin
          n_bad++;
          $display("FAIL ctrl_vec iter=%0d t=%0t got=%b want=%b",
                   iters[k], $time, act, exp_v);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    // Reset held two cycles, then idle
    cycles(2);
    reset = 1'b0;
    cycles(5);

    // Single start pulse
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(14);

    // Start held high: back-to-back divisions, no restarts while busy/done
    start = 1'b1;
    cycles(40);
    start = 1'b0;
    cycles(12);

    // Reset during the second AI cycle of the ITER=3 instance
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(4);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(3);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(14);

    // Random start pulses/holds with occasional resets
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 60) == 0);
      cycles(1);
    end
    start = 1'b0;
    reset = 1'b0;
    cycles(20);

    if (n_cmp < 900) begin
      n_bad++;
      $display("FAIL compare_count got=%0d want>=900", n_cmp);
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
